// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the sequential multiplier controller.
//   DEFAULT_WIDTH : default operand width / number of add-shift steps
//   state_t       : controller state encoding (4-bit, upper codes unused)
//   ctrl_t        : registered control-output bundle
//   is_busy()     : states in which a multiply is in progress
package mult_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // 4-bit encoding leaves codes 8..15 unused; they recover to ST_IDLE.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'h0,
        ST_LOAD  = 4'h1,
        ST_READY = 4'h2,
        ST_CLRXA = 4'h3,
        ST_ARITH = 4'h4,
        ST_SHIFT = 4'h5,
        ST_HALT  = 4'h6,
        ST_HOLD  = 4'h7
    } state_t;

    typedef struct packed {
        logic shift;
        logic add;
        logic sub;
        logic clr_ld;
        logic clr_xa;
        logic busy;
        logic done;
    } ctrl_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_CLRXA) || (s == ST_ARITH) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// Step counter for the add/shift sequence.
//   Clk, Reset : clock, asynchronous active-low reset
//   clr        : force the count to 0 (wins over inc)
//   inc        : advance by one; saturates at WIDTH-1
//   cnt        : current step index, 0..WIDTH-1
//   last_c     : cnt == WIDTH-1 (sign step)
//   pen_c      : cnt == WIDTH-2 (next increment reaches the sign step)
module mult_step_cnt
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last_c,
    output logic          pen_c
);

    localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN_VAL  = CW'(WIDTH - 2);

    logic [CW-1:0] cnt_nxt;

    // Next count: clear has priority, increment never wraps past the sign step.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && !last_c) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign last_c = (cnt == LAST_VAL);
    assign pen_c  = (cnt == PEN_VAL);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for a shift-add two's-complement multiplier (X:A:B chain).
// Optional build macro: MULT_SEQ_CTRL_SKIP_EN -- when defined, a step whose
// sampled multiplier bit M is 0 skips the ARITH cycle; otherwise every step
// goes through ARITH and the datapath qualifies Add/Sub with M.
//   Clk, Reset : clock, asynchronous active-low reset
//   Run        : level start/continue request
//   LoadClear  : load B and clear accumulator
//   M          : current multiplier LSB
//   Shift      : shift X:A:B right one place
//   Add / Sub  : add S into A (steps 0..WIDTH-2) / subtract S (step WIDTH-1)
//   Op         : Add | Sub
//   Clr_Ld     : clear X/A and load B
//   Clr_XA     : clear X and A only
//   Busy       : multiply in progress (CLRXA, ARITH, SHIFT)
//   Done       : result valid (HALT)
//   Step       : current step index
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          LoadClear,
    input  logic          M,
    output logic          Shift,
    output logic          Add,
    output logic          Sub,
    output logic          Op,
    output logic          Clr_Ld,
    output logic          Clr_XA,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Step
);

`ifdef MULT_SEQ_CTRL_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    state_t state;
    state_t state_nxt;
    state_t first_c;
    ctrl_t  ctrl;
    ctrl_t  ctrl_nxt;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   step_last_c;
    logic   step_pen_c;
    logic   next_last;

    mult_step_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step_cnt (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .cnt    (Step),
        .last_c (step_last_c),
        .pen_c  (step_pen_c)
    );

    // State entered at the start of each step.
    assign first_c = (M || !SKIP_EN) ? ST_ARITH : ST_SHIFT;

    // Next state, counter control, and next-cycle Moore outputs.
    // next_last tells the decode whether the step being entered is the sign step,
    // so Add/Sub can be registered together with the state.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        next_last = step_last_c;
        ctrl_nxt  = '0;

        case (state)
            ST_IDLE: begin
                if (LoadClear) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_READY;
            end
            ST_READY: begin
                if (LoadClear) begin
                    state_nxt = ST_LOAD;
                end else if (Run) begin
                    cnt_clr   = 1'b1;
                    next_last = 1'b0;
                    state_nxt = first_c;
                end
            end
            ST_CLRXA: begin
                cnt_clr   = 1'b1;
                next_last = 1'b0;
                state_nxt = first_c;
            end
            ST_ARITH: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (step_last_c) begin
                    state_nxt = ST_HALT;
                end else begin
                    cnt_inc   = 1'b1;
                    next_last = step_pen_c;
                    state_nxt = first_c;
                end
            end
            ST_HALT: begin
                if (!Run) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (LoadClear) begin
                    state_nxt = ST_LOAD;
                end else if (Run) begin
                    state_nxt = ST_CLRXA;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ctrl_nxt.shift  = (state_nxt == ST_SHIFT);
        ctrl_nxt.add    = (state_nxt == ST_ARITH) && !next_last;
        ctrl_nxt.sub    = (state_nxt == ST_ARITH) && next_last;
        ctrl_nxt.clr_ld = (state_nxt == ST_LOAD);
        ctrl_nxt.clr_xa = (state_nxt == ST_CLRXA);
        ctrl_nxt.busy   = is_busy(state_nxt);
        ctrl_nxt.done   = (state_nxt == ST_HALT);
    end

    // State and registered control outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            ctrl  <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_nxt;
        end
    end

    assign Shift  = ctrl.shift;
    assign Add    = ctrl.add;
    assign Sub    = ctrl.sub;
    assign Clr_Ld = ctrl.clr_ld;
    assign Clr_XA = ctrl.clr_xa;
    assign Busy   = ctrl.busy;
    assign Done   = ctrl.done;
    assign Op     = ctrl.add | ctrl.sub;

endmodule
